// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the receive detection controller.
package rx_ctrl_pkg;

  // Result and counter widths
  localparam int unsigned ValueW     = 41;
  localparam int unsigned SeqW       = 4;
  localparam int unsigned TimeW      = 32;
  localparam int unsigned CountW     = 16;
  localparam int unsigned SampleCntW = 32;

  // Default timing: 0.1 s echo blanking and 10 s listen window at 44.1 kHz
  localparam int unsigned DefHoldoffSamples = 4410;
  localparam int unsigned DefListenTimeout  = 441000;

  typedef enum logic [2:0] {
    StIdle,
    StListen,
    StReport,
    StRelease,
    StHoldoff
  } rx_state_e;

endpackage

// File: rtl/rx_sample_counter.sv
// Sample-strobe counter with synchronous clear and an equality compare
// against a runtime limit. It stops at the limit, so it can never wrap.
module rx_sample_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [Width-1:0] limit_i,
  output logic             at_limit_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear wins over increment; increment only below the limit
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q < limit_i)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit_o = (count_q == limit_i);

endmodule

// File: rtl/rx_detection_controller.sv
// Receive detection controller: arms the peak identifier, latches and reports
// detections or listen timeouts to the host, and blanks echoes afterwards.
module rx_detection_controller
  import rx_ctrl_pkg::*;
#(
  parameter int unsigned              HOLDOFF_SAMPLES = DefHoldoffSamples,
  parameter int unsigned              LISTEN_TIMEOUT  = DefListenTimeout,
  parameter logic signed [ValueW-1:0] MIN_PEAK        = '0
) (
  input  logic                     crx_clk,
  input  logic                     rrx_rst,
  input  logic                     istart,
  input  logic                     istop,
  input  logic                     icontinuous,
  input  logic                     inew_sample_trigger,
  input  logic                     ipeak_trigger,
  input  logic signed [ValueW-1:0] ipeak_value,
  input  logic [SeqW-1:0]          ipeak_seq,
  input  logic [TimeW-1:0]         ipeak_time,
  input  logic                     iack,
  output logic                     oen_peak,
  output logic                     oresult_acquired,
  output logic                     ovalid,
  output logic [ValueW-1:0]        ovalue,
  output logic [SeqW-1:0]          oseq,
  output logic [TimeW-1:0]         otime,
  output logic                     otimeout,
  output logic                     obusy,
  output logic [CountW-1:0]        odetect_count
);

  localparam logic [SampleCntW-1:0] HoldoffLimit = SampleCntW'(HOLDOFF_SAMPLES);
  localparam logic [SampleCntW-1:0] ListenLimit  = SampleCntW'(LISTEN_TIMEOUT);

  rx_state_e state_q, state_d;

  logic              discard_q, discard_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
  logic [ValueW-1:0] value_q, value_d;
  logic [SeqW-1:0]   seq_q, seq_d;
  logic [TimeW-1:0]  time_q, time_d;
  logic [CountW-1:0] count_q, count_d;
  logic              en_q, en_d;
  logic              acq_q, acq_d;
  logic              busy_q, busy_d;

  logic                  cnt_clear;
  logic                  cnt_inc;
  logic                  cnt_at_limit;
  logic [SampleCntW-1:0] cnt_limit;

  // One counter serves both windows; the limit follows the state
  assign cnt_limit = (state_q == StHoldoff) ? HoldoffLimit : ListenLimit;

  rx_sample_counter #(
    .Width(SampleCntW)
  ) u_sample_counter (
    .clk_i     (crx_clk),
    .rst_ni    (rrx_rst),
    .clear_i   (cnt_clear),
    .inc_i     (cnt_inc),
    .limit_i   (cnt_limit),
    .at_limit_o(cnt_at_limit)
  );

  // Next-state and result logic; istop overrides everything
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    value_d   = value_q;
    seq_d     = seq_q;
    time_d    = time_q;
    count_d   = count_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;

    if (istop) begin
      state_d   = StIdle;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (istart) begin
            state_d   = StListen;
            cnt_clear = 1'b1;
            count_d   = '0;
          end
        end
        StListen: begin
          cnt_inc = inew_sample_trigger;
          if (ipeak_trigger) begin
            if (ipeak_value >= MIN_PEAK) begin
              value_d   = ipeak_value;
              seq_d     = ipeak_seq;
              time_d    = ipeak_time;
              timeout_d = 1'b0;
              valid_d   = 1'b1;
              state_d   = StReport;
            end else begin
              discard_d = 1'b1;
              state_d   = StRelease;
            end
          end else if (cnt_at_limit) begin
            value_d   = '0;
            seq_d     = '0;
            time_d    = '0;
            timeout_d = 1'b1;
            valid_d   = 1'b1;
            state_d   = StReport;
          end
        end
        StReport: begin
          if (iack) begin
            valid_d   = 1'b0;
            discard_d = 1'b0;
            state_d   = StRelease;
            if (!timeout_q && (count_q != '1)) begin
              count_d = count_q + 1'b1;
            end
          end
        end
        StRelease: begin
          if (discard_q) begin
            // Discarded peak: resume the same listen window
            state_d = StListen;
          end else if (icontinuous) begin
            state_d   = StHoldoff;
            cnt_clear = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
        StHoldoff: begin
          if (cnt_at_limit) begin
            state_d   = StListen;
            cnt_clear = 1'b1;
          end else begin
            cnt_inc = inew_sample_trigger;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Registered status outputs decoded from the upcoming state
  always_comb begin
    en_d   = (state_d == StListen) || (state_d == StReport) || (state_d == StRelease);
    acq_d  = (state_d == StRelease);
    busy_d = (state_d != StIdle);
  end

  // State, result and output registers
  always_ff @(posedge crx_clk or negedge rrx_rst) begin
    if (!rrx_rst) begin
      state_q   <= StIdle;
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      value_q   <= '0;
      seq_q     <= '0;
      time_q    <= '0;
      count_q   <= '0;
      en_q      <= 1'b0;
      acq_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      value_q   <= value_d;
      seq_q     <= seq_d;
      time_q    <= time_d;
      count_q   <= count_d;
      en_q      <= en_d;
      acq_q     <= acq_d;
      busy_q    <= busy_d;
    end
  end

  assign oen_peak         = en_q;
  assign oresult_acquired = acq_q;
  assign ovalid           = valid_q;
  assign ovalue           = value_q;
  assign oseq             = seq_q;
  assign otime            = time_q;
  assign otimeout         = timeout_q;
  assign obusy            = busy_q;
  assign odetect_count    = count_q;

endmodule
